// File: rtl/kanagawa_cycle_timer_pkg.sv
// Shared types for the kanagawa cycle timer.
package kanagawa_cycle_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/kanagawa_cycle_timer.sv
// Loadable down-counter with a done handshake and cancel.
// Define KANAGAWA_CYCLE_TIMER_RELOAD_EN to add auto_reload and a period register.
module kanagawa_cycle_timer
  import kanagawa_cycle_timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_count,
  output logic             load_ready,
  input  logic             cancel,
`ifdef KANAGAWA_CYCLE_TIMER_RELOAD_EN
  input  logic             auto_reload,
`endif
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] count_out,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
`ifdef KANAGAWA_CYCLE_TIMER_RELOAD_EN
  logic [WIDTH-1:0] period_q, period_d;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
`ifdef KANAGAWA_CYCLE_TIMER_RELOAD_EN
    period_d = period_q;
`endif
    case (state_q)
      ST_IDLE: begin
        count_d = '0;
        if (load_valid) begin
`ifdef KANAGAWA_CYCLE_TIMER_RELOAD_EN
          period_d = load_count;
`endif
          if (load_count == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            count_d = load_count;
          end
        end
      end
      ST_RUN: begin
        // Count is >=1 while running; the <=1 test also keeps it from wrapping.
        if (count_q <= WIDTH'(1)) begin
          state_d = ST_DONE;
          count_d = '0;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
      ST_DONE: begin
        count_d = '0;
        if (done_ready) begin
`ifdef KANAGAWA_CYCLE_TIMER_RELOAD_EN
          if (!auto_reload) begin
            state_d = ST_IDLE;
          end else if (period_q == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            count_d = period_q;
          end
`else
          state_d = ST_IDLE;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
    // Cancel overrides decrement, expiry and the done handshake.
    if (cancel && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

`ifdef KANAGAWA_CYCLE_TIMER_RELOAD_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) period_q <= '0;
    else      period_q <= period_d;
  end
`endif

  assign load_ready = (state_q == ST_IDLE);
  assign done_valid = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign count_out  = count_q;

endmodule

// File: tb/tb_kanagawa_cycle_timer.sv
// Directed bench for kanagawa_cycle_timer (32-bit and 4-bit instances).
module tb_kanagawa_cycle_timer;

  logic        clk;
  logic        rst;
  logic        load_valid, cancel, done_ready;
  logic [31:0] load_count;
  logic        load_ready, done_valid, busy;
  logic [31:0] count_out;

  logic        lv4, can4, dr4;
  logic [3:0]  lc4;
  logic        lr4, dv4, busy4;
  logic [3:0]  co4;

`ifdef KANAGAWA_CYCLE_TIMER_RELOAD_EN
  logic auto_reload, ar4;
`endif

  int checks = 0;
  int failures = 0;

  kanagawa_cycle_timer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_count(load_count), .load_ready(load_ready),
    .cancel(cancel),
`ifdef KANAGAWA_CYCLE_TIMER_RELOAD_EN
    .auto_reload(auto_reload),
`endif
    .done_valid(done_valid), .done_ready(done_ready),
    .count_out(count_out), .busy(busy)
  );

  kanagawa_cycle_timer #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .load_valid(lv4), .load_count(lc4), .load_ready(lr4),
    .cancel(can4),
`ifdef KANAGAWA_CYCLE_TIMER_RELOAD_EN
    .auto_reload(ar4),
`endif
    .done_valid(dv4), .done_ready(dr4),
    .count_out(co4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk1({tag, "_ready"}, load_ready, 1'b1);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_dv"}, done_valid, 1'b0);
    chkw({tag, "_cnt"}, count_out, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    load_valid = 1'b0; load_count = '0; cancel = 1'b0; done_ready = 1'b0;
    lv4 = 1'b0; lc4 = '0; can4 = 1'b0; dr4 = 1'b0;
`ifdef KANAGAWA_CYCLE_TIMER_RELOAD_EN
    auto_reload = 1'b0; ar4 = 1'b0;
`endif
    #3;
    chk_idle("reset");
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk_idle("post_reset");

    // N=5: 5,4,3,2,1 then DONE five cycles after accept; load in RUN ignored
    load_valid = 1'b1; load_count = 32'd5;
    tick();
    load_count = 32'd99;
    chkw("n5_cnt5", count_out, 32'd5);
    chk1("n5_busy", busy, 1'b1);
    chk1("n5_ready", load_ready, 1'b0);
    for (int i = 4; i >= 1; i--) begin
      tick();
      chkw("n5_cnt", count_out, 32'(i));
      chk1("n5_dv_low", done_valid, 1'b0);
    end
    tick();
    load_valid = 1'b0;
    chk1("n5_dv", done_valid, 1'b1);
    chkw("n5_cnt0", count_out, 32'd0);
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    chk_idle("n5_ack");

    // N=0: DONE right after accept, held for 10 cycles without ack
    load_valid = 1'b1; load_count = 32'd0;
    tick();
    load_valid = 1'b0;
    chk1("n0_dv", done_valid, 1'b1);
    chk1("n0_busy", busy, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk1("n0_hold", done_valid, 1'b1);
      chkw("n0_cnt", count_out, 32'd0);
    end
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    chk_idle("n0_ack");

    // N=100 cancelled at 40
    load_valid = 1'b1; load_count = 32'd100;
    tick();
    load_valid = 1'b0;
    repeat (60) tick();
    chkw("n100_cnt40", count_out, 32'd40);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk_idle("n100_cancel");

    // cancel together with done_ready in DONE
    load_valid = 1'b1; load_count = 32'd0;
    tick();
    load_valid = 1'b0;
    chk1("cdone_dv", done_valid, 1'b1);
    cancel = 1'b1; done_ready = 1'b1;
    tick();
    cancel = 1'b0; done_ready = 1'b0;
    chk_idle("cdone");

    // cancel beats expiry on the 1->0 edge
    load_valid = 1'b1; load_count = 32'd1;
    tick();
    load_valid = 1'b0;
    chkw("cexp_cnt1", count_out, 32'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk_idle("cexp");

    // cancel in IDLE with a simultaneous load: load accepted
    cancel = 1'b1; load_valid = 1'b1; load_count = 32'd2;
    tick();
    cancel = 1'b0; load_valid = 1'b0;
    chkw("cidle_cnt2", count_out, 32'd2);
    chk1("cidle_busy", busy, 1'b1);
    tick();
    chkw("cidle_cnt1", count_out, 32'd1);
    tick();
    chk1("cidle_dv", done_valid, 1'b1);
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;

    // async reset mid-count, then a load on the first edge after release
    load_valid = 1'b1; load_count = 32'd50;
    tick();
    load_valid = 1'b0;
    repeat (30) tick();
    chkw("rst_cnt20", count_out, 32'd20);
    #2;
    rst = 1'b0;
    #1;
    chk_idle("rst_async");
    tick();
    chk_idle("rst_held");
    rst = 1'b1;
    load_valid = 1'b1; load_count = 32'd3;
    tick();
    load_valid = 1'b0;
    chkw("rst_n3_cnt3", count_out, 32'd3);
    tick();
    chkw("rst_n3_cnt2", count_out, 32'd2);
    tick();
    chkw("rst_n3_cnt1", count_out, 32'd1);
    chk1("rst_n3_dv_low", done_valid, 1'b0);
    tick();
    chk1("rst_n3_dv", done_valid, 1'b1);
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    chk_idle("rst_n3_ack");

    // WIDTH=4, N=15: full countdown without wrap
    lv4 = 1'b1; lc4 = 4'd15;
    tick();
    lv4 = 1'b0;
    chkw("w4_cnt15", {28'd0, co4}, 32'd15);
    for (int i = 14; i >= 1; i--) begin
      tick();
      chkw("w4_cnt", {28'd0, co4}, 32'(i));
      chk1("w4_dv_low", dv4, 1'b0);
    end
    tick();
    chk1("w4_dv", dv4, 1'b1);
    chkw("w4_cnt0", {28'd0, co4}, 32'd0);
    tick();
    chkw("w4_hold0", {28'd0, co4}, 32'd0);
    dr4 = 1'b1;
    tick();
    dr4 = 1'b0;
    chk1("w4_ready", lr4, 1'b1);

`ifdef KANAGAWA_CYCLE_TIMER_RELOAD_EN
    // auto-reload N=4: done every 5th cycle, then auto_reload=0 goes idle
    auto_reload = 1'b1; done_ready = 1'b1;
    load_valid = 1'b1; load_count = 32'd4;
    tick();
    load_valid = 1'b0;
    chkw("ar_cnt4", count_out, 32'd4);
    for (int k = 1; k < 10; k++) begin
      tick();
      chk1("ar_dv", done_valid, (k % 5) == 4);
    end
    auto_reload = 1'b0;
    tick();
    done_ready = 1'b0;
    chk_idle("ar_off");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
